// File: rtl/worldmap_rd_arbiter.sv
// Round-robin arbiter sharing one world-map BRAM read port between two Rojobots.
// Responses are id-tagged through a fixed-latency pipeline; contention is counted for debug.
module worldmap_rd_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 2,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [CNT_W-1:0]  contention_cnt,
    input  logic              contention_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  grant_any_s;
    logic                  grant_id_s;
    logic                  last_r;
    logic [ADDR_W-1:0]     addr_hold_r;
    logic [RD_LATENCY-1:0] tag_valid_r;
    logic [RD_LATENCY-1:0] tag_id_r;
    logic                  tag_out_valid_s;
    logic                  tag_out_id_s;

    // Round-robin selection: on a tie the requester that did not win last time is chosen
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                grant_any_s = 1'b1;
                grant_id_s  = 1'b0;
            end
            2'b10: begin
                grant_any_s = 1'b1;
                grant_id_s  = 1'b1;
            end
            2'b11: begin
                grant_any_s = 1'b1;
                grant_id_s  = ~last_r;
            end
            default: begin
                grant_any_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        endcase
    end

    // Same-cycle grant outputs; the BRAM address holds when nobody is granted
    always_comb begin
        req0_ready = grant_any_s & ~grant_id_s;
        req1_ready = grant_any_s & grant_id_s;
        mem_en     = grant_any_s;
        if (grant_any_s) begin
            if (grant_id_s) begin
                mem_addr = req1_addr;
            end else begin
                mem_addr = req0_addr;
            end
        end else begin
            mem_addr = addr_hold_r;
        end
    end

    // Round-robin pointer and held address; reset pointer favours requester 0 on the first tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_r      <= 1'b1;
            addr_hold_r <= {ADDR_W{1'b0}};
        end else if (grant_any_s) begin
            last_r      <= grant_id_s;
            addr_hold_r <= mem_addr;
        end
    end

    // Tag pipeline tracking which requester owns each outstanding BRAM read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_valid_r <= {RD_LATENCY{1'b0}};
            tag_id_r    <= {RD_LATENCY{1'b0}};
        end else begin
            tag_valid_r[0] <= grant_any_s;
            tag_id_r[0]    <= grant_id_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
        end
    end

    assign tag_out_valid_s = tag_valid_r[RD_LATENCY-1];
    assign tag_out_id_s    = tag_id_r[RD_LATENCY-1];

    // Response capture: data lands only in the owning requester's hold register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= {DATA_W{1'b0}};
            rsp1_data  <= {DATA_W{1'b0}};
        end else begin
            rsp0_valid <= tag_out_valid_s & ~tag_out_id_s;
            rsp1_valid <= tag_out_valid_s & tag_out_id_s;
            if (tag_out_valid_s && !tag_out_id_s) begin
                rsp0_data <= mem_data;
            end
            if (tag_out_valid_s && tag_out_id_s) begin
                rsp1_data <= mem_data;
            end
        end
    end

    // Saturating contention counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            contention_cnt <= {CNT_W{1'b0}};
        end else if (contention_clr) begin
            contention_cnt <= {CNT_W{1'b0}};
        end else if (req0_valid && req1_valid && (contention_cnt != CNT_MAX)) begin
            contention_cnt <= contention_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_worldmap_rd_arbiter.sv
// Bench for worldmap_rd_arbiter: two instances (latency 1 / 16-bit counter, latency 3 / 4-bit counter)
// share stimulus; a queue-free cycle-slot reference model plus fixed vectors check both.
module tb_worldmap_rd_arbiter;

    logic        clk, rstn, v0, v1, clr;
    logic [13:0] a0, a1;

    logic        a_r0, a_r1, a_v0, a_v1, a_en;
    logic [1:0]  a_d0, a_d1, a_md;
    logic [13:0] a_addr;
    logic [15:0] a_cnt;

    logic        b_r0, b_r1, b_v0, b_v1, b_en;
    logic [1:0]  b_d0, b_d1, b_md;
    logic [13:0] b_addr;
    logic [3:0]  b_cnt;

    int n_vec, n_err;

    logic [1:0] map [0:16383];
    logic [1:0] a_pipe;
    logic [1:0] b_pipe [3];

    worldmap_rd_arbiter #(.ADDR_W(14), .DATA_W(2), .RD_LATENCY(1), .CNT_W(16)) u_a (
        .clk(clk), .rstn(rstn),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(a_r0), .rsp0_valid(a_v0), .rsp0_data(a_d0),
        .req1_valid(v1), .req1_addr(a1), .req1_ready(a_r1), .rsp1_valid(a_v1), .rsp1_data(a_d1),
        .mem_en(a_en), .mem_addr(a_addr), .mem_data(a_md),
        .contention_cnt(a_cnt), .contention_clr(clr)
    );

    worldmap_rd_arbiter #(.ADDR_W(14), .DATA_W(2), .RD_LATENCY(3), .CNT_W(4)) u_b (
        .clk(clk), .rstn(rstn),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(b_r0), .rsp0_valid(b_v0), .rsp0_data(b_d0),
        .req1_valid(v1), .req1_addr(a1), .req1_ready(b_r1), .rsp1_valid(b_v1), .rsp1_data(b_d1),
        .mem_en(b_en), .mem_addr(b_addr), .mem_data(b_md),
        .contention_cnt(b_cnt), .contention_clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models with 1- and 3-cycle read latency
    always @(posedge clk) begin
        if (a_en) a_pipe <= map[a_addr];
        if (b_en) b_pipe[0] <= map[b_addr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_md = a_pipe;
    assign b_md = b_pipe[2];

    // Reference model state: responses are filed in a ring indexed by the cycle they are due
    bit          m_last, m_known, m_g_any, m_g_id;
    logic [13:0] m_hold;
    int          m_cyc;
    int          m_cnt [2];
    logic [1:0]  m_data [2][2];
    bit          ring_v [2][8];
    bit          ring_id [2][8];
    logic [1:0]  ring_d [2][8];
    int          lat [2];
    int          cmax [2];

    typedef struct {
        logic        v0, v1;
        logic [13:0] a0, a1;
        logic        e_r0, e_r1;
        logic [13:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl [12];

    function automatic vec_t mk(input logic pv0, input logic pv1, input logic [13:0] pa0,
                                input logic [13:0] pa1, input logic er0, input logic er1,
                                input logic [13:0] ea, input logic [15:0] ec);
        vec_t r;
        r.v0 = pv0; r.v1 = pv1; r.a0 = pa0; r.a1 = pa1;
        r.e_r0 = er0; r.e_r1 = er1; r.e_addr = ea; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_known = 1'b0;
        m_hold  = 14'd0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_data[k][0] = 2'd0;
            m_data[k][1] = 2'd0;
            for (int s = 0; s < 8; s++) begin
                ring_v[k][s] = 1'b0;
                ring_id[k][s] = 1'b0;
                ring_d[k][s] = 2'd0;
            end
        end
    endtask

    // One cycle: compare every output against the model, then advance the model past the edge
    task automatic tick();
        logic        g_any, g_id, act_v0, act_v1;
        logic [13:0] g_addr;
        logic [1:0]  act_d0, act_d1;
        logic [31:0] act_c;
        int          slot, s2;
        #1;
        g_any  = v0 | v1;
        g_id   = (v0 && v1) ? ~m_last : v1;
        g_addr = g_id ? a1 : a0;
        chk("ready0_a", 32'(a_r0), 32'(g_any && !g_id));
        chk("ready1_a", 32'(a_r1), 32'(g_any && g_id));
        chk("ready0_b", 32'(b_r0), 32'(g_any && !g_id));
        chk("ready1_b", 32'(b_r1), 32'(g_any && g_id));
        chk("mem_en", 32'({a_en, b_en}), 32'({g_any, g_any}));
        if (g_any) begin
            chk("mem_addr_a", 32'(a_addr), 32'(g_addr));
            chk("mem_addr_b", 32'(b_addr), 32'(g_addr));
        end else if (m_known) begin
            chk("mem_addr_hold_a", 32'(a_addr), 32'(m_hold));
            chk("mem_addr_hold_b", 32'(b_addr), 32'(m_hold));
        end
        slot = m_cyc % 8;
        for (int k = 0; k < 2; k++) begin
            if (ring_v[k][slot]) m_data[k][ring_id[k][slot]] = ring_d[k][slot];
            act_v0 = (k == 0) ? a_v0 : b_v0;
            act_v1 = (k == 0) ? a_v1 : b_v1;
            act_d0 = (k == 0) ? a_d0 : b_d0;
            act_d1 = (k == 0) ? a_d1 : b_d1;
            act_c  = (k == 0) ? 32'(a_cnt) : 32'(b_cnt);
            chk($sformatf("rsp0_valid[%0d]", k), 32'(act_v0), 32'(ring_v[k][slot] && !ring_id[k][slot]));
            chk($sformatf("rsp1_valid[%0d]", k), 32'(act_v1), 32'(ring_v[k][slot] && ring_id[k][slot]));
            chk($sformatf("rsp0_data[%0d]", k), 32'(act_d0), 32'(m_data[k][0]));
            chk($sformatf("rsp1_data[%0d]", k), 32'(act_d1), 32'(m_data[k][1]));
            chk($sformatf("contention_cnt[%0d]", k), act_c, 32'(m_cnt[k]));
            ring_v[k][slot] = 1'b0;
        end
        if (g_any) begin
            for (int k = 0; k < 2; k++) begin
                s2 = (m_cyc + lat[k] + 1) % 8;
                ring_v[k][s2]  = 1'b1;
                ring_id[k][s2] = g_id;
                ring_d[k][s2]  = map[g_addr];
            end
            m_last  = g_id;
            m_hold  = g_addr;
            m_known = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (clr) m_cnt[k] = 0;
            else if (v0 && v1 && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        m_g_any = g_any;
        m_g_id  = g_id;
        m_cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic hold0, hold1;
        n_vec = 0; n_err = 0; m_cyc = 0;
        lat[0] = 1; lat[1] = 3;
        cmax[0] = 65535; cmax[1] = 15;
        rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; clr = 1'b0; a0 = 14'd0; a1 = 14'd0;
        for (int i = 0; i < 16384; i++) map[i] = 2'($urandom);
        map[14'h0123] = 2'd2;
        model_reset();

        @(negedge clk);
        tick();
        rstn = 1'b1;

        // Single requester, pixel value 2 at 0x0123
        v0 = 1'b1; a0 = 14'h0123;
        #1;
        chk("t1_ready0", 32'(a_r0), 32'd1);
        chk("t1_addr", 32'(a_addr), 32'h0123);
        tick();
        v0 = 1'b0;
        tick();
        #1;
        chk("t1_rsp0_valid", 32'(a_v0), 32'd1);
        chk("t1_rsp0_data", 32'(a_d0), 32'd2);
        chk("t1_rsp1_valid", 32'(a_v1), 32'd0);
        chk("t1_rsp1_data", 32'(a_d1), 32'd0);
        tick();
        repeat (4) tick();

        // Fixed vectors: solo 1, six contended cycles, tie after solo traffic, hold, more ties
        tbl[0]  = mk(1'b0, 1'b1, 14'h0000, 14'h0040, 1'b0, 1'b1, 14'h0040, 16'd0);
        tbl[1]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 14'h0010, 16'd0);
        tbl[2]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b0, 1'b1, 14'h0020, 16'd1);
        tbl[3]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 14'h0010, 16'd2);
        tbl[4]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b0, 1'b1, 14'h0020, 16'd3);
        tbl[5]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 14'h0010, 16'd4);
        tbl[6]  = mk(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b0, 1'b1, 14'h0020, 16'd5);
        tbl[7]  = mk(1'b0, 1'b1, 14'h0010, 14'h0021, 1'b0, 1'b1, 14'h0021, 16'd6);
        tbl[8]  = mk(1'b1, 1'b1, 14'h0012, 14'h0022, 1'b1, 1'b0, 14'h0012, 16'd6);
        tbl[9]  = mk(1'b0, 1'b0, 14'h0012, 14'h0022, 1'b0, 1'b0, 14'h0012, 16'd7);
        tbl[10] = mk(1'b1, 1'b1, 14'h0013, 14'h0022, 1'b0, 1'b1, 14'h0022, 16'd7);
        tbl[11] = mk(1'b1, 1'b1, 14'h0013, 14'h0023, 1'b1, 1'b0, 14'h0013, 16'd8);
        for (int i = 0; i < 12; i++) begin
            v0 = tbl[i].v0; v1 = tbl[i].v1; a0 = tbl[i].a0; a1 = tbl[i].a1;
            #1;
            chk($sformatf("tbl%0d_ready0", i), 32'(a_r0), 32'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_ready1", i), 32'(a_r1), 32'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_addr", i), 32'(a_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].e_cnt));
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) tick();

        // Latency-3 instance: back-to-back reads of 1,2,3 return on consecutive cycles
        v0 = 1'b1; a0 = 14'd1; tick();
        a0 = 14'd2; tick();
        a0 = 14'd3; tick();
        v0 = 1'b0;
        #1 chk("t4_early", 32'(b_v0), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_valid%0d", i), 32'(b_v0), 32'd1);
            chk($sformatf("t4_data%0d", i), 32'(b_d0), 32'(map[i+1]));
            tick();
        end
        #1 chk("t4_late", 32'(b_v0), 32'd0);
        tick();

        // Reset with reads in flight
        v0 = 1'b1; a0 = 14'd5; tick();
        v0 = 1'b0; v1 = 1'b1; a1 = 14'd6; tick();
        v1 = 1'b0;
        rstn = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
        #1;
        chk("t5_cnt_a", 32'(a_cnt), 32'd0);
        chk("t5_cnt_b", 32'(b_cnt), 32'd0);
        chk("t5_data", 32'({a_d0, a_d1, b_d0, b_d1}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t5_no_rsp%0d", i), 32'({a_v0, a_v1, b_v0, b_v1}), 32'd0);
            tick();
        end
        v0 = 1'b1; v1 = 1'b1; a0 = 14'd7; a1 = 14'd8;
        #1;
        chk("t5_tie_ready0", 32'(a_r0), 32'd1);
        chk("t5_tie_ready1", 32'(a_r1), 32'd0);
        tick();

        // Counter saturation on the 4-bit instance, then clear during contention
        a0 = 14'd9; a1 = 14'd10;
        repeat (20) tick();
        #1;
        chk("t6_sat_b", 32'(b_cnt), 32'hF);
        chk("t6_cnt_a", 32'(a_cnt), 32'd21);
        clr = 1'b1;
        tick();
        clr = 1'b0; v0 = 1'b0; v1 = 1'b0;
        #1;
        chk("t6_clr_a", 32'(a_cnt), 32'd0);
        chk("t6_clr_b", 32'(b_cnt), 32'd0);
        tick();

        // Randomized traffic obeying the address-stability rule
        for (int n = 0; n < 500; n++) begin
            hold0 = v0 && !(m_g_any && !m_g_id);
            hold1 = v1 && !(m_g_any && m_g_id);
            if (hold0) begin
                if ($urandom_range(7, 0) == 0) v0 = 1'b0;
            end else begin
                v0 = ($urandom_range(2, 0) != 0);
                a0 = 14'($urandom);
            end
            if (hold1) begin
                if ($urandom_range(7, 0) == 0) v1 = 1'b0;
            end else begin
                v1 = ($urandom_range(2, 0) != 0);
                a1 = 14'($urandom);
            end
            clr = ($urandom_range(31, 0) == 0);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; clr = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/worldmap_rd_arbiter.md
Name: worldmap_rd_arbiter

Overview:
- Shares one read port of the world-map block RAM between two Rojobot requesters (bot 0, bot 1), so both bots sense the same map through a single port.
- Arbitration is round-robin. One accepted request per cycle.
- Each response is tagged back to the requester that issued it, with fixed latency.
- Sits between the two Rojobot instances and the map BRAM, in the 75 MHz video/bot clock domain.
- Exposes a saturating contention counter for Wishbone debug readback.

Parameters:
- ADDR_W, 14, map address width (128x128 map).
- DATA_W, 2, map pixel width.
- RD_LATENCY, 1, BRAM read latency in cycles from mem_addr to mem_data valid (1..4).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  arbiter clock (75 MHz domain)
- rstn  in  1  asynchronous active-low reset
- req0_valid  in  1  bot 0 read request
- req0_addr  in  ADDR_W  bot 0 map address
- req0_ready  out  1  bot 0 request accepted this cycle
- rsp0_valid  out  1  one-cycle pulse: rsp0_data updated
- rsp0_data  out  DATA_W  last map value returned to bot 0 (held)
- req1_valid  in  1  bot 1 read request
- req1_addr  in  ADDR_W  bot 1 map address
- req1_ready  out  1  bot 1 request accepted this cycle
- rsp1_valid  out  1  one-cycle pulse: rsp1_data updated
- rsp1_data  out  DATA_W  last map value returned to bot 1 (held)
- mem_en  out  1  BRAM read enable
- mem_addr  out  ADDR_W  BRAM read address
- mem_data  in  DATA_W  BRAM read data
- contention_cnt  out  CNT_W  count of cycles where both requesters were valid (saturating)
- contention_clr  in  1  synchronous clear of contention_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - contention_cnt = 0.
  - Round-robin pointer `last` = 1, so requester 0 wins the first tie.
  - Latency pipeline cleared.
- Selection (combinational, cycle T):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester not equal to `last`.
  - Neither valid: no grant.
- Grant outputs (cycle T):
  - reqN_ready = 1 only for the granted requester.
  - mem_en = 1 when any grant is made.
  - mem_addr = the granted requester's address. It holds its previous value when there is no grant.
  - Ready never depends on ready; there are no combinational loops.
- `last` update: on a grant, `last` <= granted id at the clock edge. No grant leaves `last` unchanged.
- Fairness: a requester holding valid high is granted within 2 cycles. Alternation is strict under continuous contention.
- Requester rule: reqN_addr must stay stable while reqN_valid=1 and reqN_ready=0. A requester may drop valid without being granted; nothing is issued in that case.
- Tag pipeline: a (valid, id) pair is shifted through RD_LATENCY stages. mem_data is sampled when the tag exits the pipeline, at edge T+RD_LATENCY.
- Response (cycle T+RD_LATENCY+1):
  - rspN_data <= mem_data for the tagged id.
  - rspN_valid pulses high for exactly 1 cycle.
  - The other requester's rsp_data is unchanged.
- Latency: accept to rsp_valid is RD_LATENCY+1 cycles. Back-to-back grants produce back-to-back responses in grant order.
- Data hold: rspN_data holds until the next response for N, so the bot sees stable map data between reads.
- Contention counter:
  - Increments by 1 on each cycle where req0_valid & req1_valid.
  - Saturates at all-ones; no wrap.
  - contention_clr takes priority over an increment in the same cycle. Cleared value is 0.
- Reset mid-operation: in-flight tags are discarded. No rsp_valid is emitted after rstn deasserts for requests accepted before reset. The first post-reset tie goes to requester 0.
- Simultaneous response and new grant in the same cycle is legal; the pipeline is fully overlapped.

Test Plan:
1. Single requester: req0_valid=1, addr=0x0123 for 1 cycle, RD_LATENCY=1, BRAM[0x0123]=2.
   - Required: req0_ready=1 and mem_addr=0x0123 same cycle.
   - Required: rsp0_valid pulse 2 cycles later, rsp0_data=2, rsp1 untouched.
2. Continuous contention: both valid for 6 cycles, addr0=0x0010, addr1=0x0020.
   - Required: grants are 0,1,0,1,0,1.
   - Required: responses arrive in the same order with correct data.
   - Required: contention_cnt=6.
3. Tie after solo traffic: req1 alone granted, then both valid.
   - Required: next grant goes to 0.
4. Latency sweep: RD_LATENCY=3, back-to-back req0 at addresses 1,2,3.
   - Required: rsp0_valid high on 3 consecutive cycles, starting 4 cycles after the first accept, with data BRAM[1..3].
5. Reset with 2 reads in flight: rstn low for 1 cycle.
   - Required: no rsp_valid afterwards.
   - Required: rsp data=0, contention_cnt=0.
   - Required: first post-reset tie grants requester 0.
6. Counter limits, CNT_W=4: 20 contention cycles.
   - Required: counter saturates at 0xF.
   - contention_clr asserted during a contention cycle: value 0 next cycle.
